// File: rtl/pool_window_feeder_if.sv
// Handshake and memory bus bundle between the pool window feeder and its environment.
interface pool_window_feeder_if #(
    parameter int ADDR_W = 16
);
    logic              go;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic [15:0]       win00;
    logic [15:0]       win01;
    logic [15:0]       win10;
    logic [15:0]       win11;
    logic              pool_start;
    logic              pool_finish;
    logic [15:0]       pool_pixel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (
        input  go, rd_data, pool_finish, pool_pixel,
        output busy, done, rd_en, rd_addr,
        output win00, win01, win10, win11,
        output pool_start, wr_en, wr_addr, wr_data
    );

    modport slave (
        output go, rd_data, pool_finish, pool_pixel,
        input  busy, done, rd_en, rd_addr,
        input  win00, win01, win10, win11,
        input  pool_start, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pool_window_feeder.sv
// Walks a stored feature map in stride-2 2x2 windows, feeds the pooling
// datapath and writes each pooled pixel to the output map.
module pool_window_feeder #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int ADDR_W   = 16,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 1024
) (
    input logic                  clk,
    input logic                  rst,
    pool_window_feeder_if.master bus
);
    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;

    localparam logic [ADDR_W-1:0] IN_A     = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] ROW_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);
    localparam logic [15:0]       LAST_COL = 16'(OW - 1);
    localparam logic [15:0]       LAST_ROW = 16'(OH - 1);

    typedef enum logic [3:0] {
        IDLE, F0, F1, F2, F3, CAP, POOL, WRITE, DONE
    } state_t;

    state_t            state;
    logic [15:0]       orow;
    logic [15:0]       ocol;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] win_base;
    logic [ADDR_W-1:0] out_ptr;
    logic [ADDR_W-1:0] next_base;
    logic              last_col;
    logic              last_row;

    // Window origins are tracked incrementally rather than multiplied out.
    always_comb begin
        last_col  = (ocol == LAST_COL);
        last_row  = (orow == LAST_ROW);
        next_base = last_col ? row_base + ROW_STEP : win_base + TWO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            orow           <= '0;
            ocol           <= '0;
            row_base       <= IN_A;
            win_base       <= IN_A;
            out_ptr        <= OUT_A;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.rd_en      <= 1'b0;
            bus.rd_addr    <= '0;
            bus.win00      <= '0;
            bus.win01      <= '0;
            bus.win10      <= '0;
            bus.win11      <= '0;
            bus.pool_start <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        state       <= F0;
                        orow        <= '0;
                        ocol        <= '0;
                        row_base    <= IN_A;
                        win_base    <= IN_A;
                        out_ptr     <= OUT_A;
                        bus.busy    <= 1'b1;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= IN_A;
                    end
                end
                F0: begin
                    state       <= F1;
                    bus.rd_addr <= win_base + ONE;
                end
                F1: begin
                    state       <= F2;
                    bus.win00   <= bus.rd_data;
                    bus.rd_addr <= win_base + ROW_A;
                end
                F2: begin
                    state       <= F3;
                    bus.win01   <= bus.rd_data;
                    bus.rd_addr <= win_base + ROW_A + ONE;
                end
                F3: begin
                    state     <= CAP;
                    bus.win10 <= bus.rd_data;
                    bus.rd_en <= 1'b0;
                end
                CAP: begin
                    state          <= POOL;
                    bus.win11      <= bus.rd_data;
                    bus.pool_start <= 1'b1;
                end
                POOL: begin
                    // Stalls here for as long as the datapath needs.
                    if (bus.pool_finish) begin
                        state          <= WRITE;
                        bus.pool_start <= 1'b0;
                        bus.wr_data    <= bus.pool_pixel;
                        bus.wr_en      <= 1'b1;
                        bus.wr_addr    <= out_ptr;
                    end
                end
                WRITE: begin
                    bus.wr_en <= 1'b0;
                    out_ptr   <= out_ptr + ONE;
                    if (last_col && last_row) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state       <= F0;
                        win_base    <= next_base;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= next_base;
                        if (last_col) begin
                            ocol     <= '0;
                            orow     <= orow + 16'd1;
                            row_base <= next_base;
                        end else begin
                            ocol <= ocol + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    orow     <= '0;
                    ocol     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder: 4x4 and 5x5 maps, stalled pooling,
// ignored go pulses, reset abort and back-to-back scans.
module tb_pool_window_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    int   dly = 0;
    int   pcnt = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pool_window_feeder_if #(.ADDR_W(16)) b4 ();
    pool_window_feeder_if #(.ADDR_W(16)) b5 ();

    pool_window_feeder #(.IMG_W(4), .IMG_H(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    pool_window_feeder #(.IMG_W(5), .IMG_H(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));

    // RAM stubs: word a holds 4*(a+1), one-cycle read latency
    always @(posedge clk) begin
        if (b4.rd_en) b4.rd_data <= (b4.rd_addr + 16'd1) << 2;
        if (b5.rd_en) b5.rd_data <= (b5.rd_addr + 16'd1) << 2;
    end

    // Pooling stubs: average of the window, plus 256 per stall cycle so the
    // captured value identifies the finish cycle.
    always_comb begin
        b4.pool_finish = b4.pool_start && (pcnt == dly);
        b4.pool_pixel  = 16'((32'(b4.win00) + 32'(b4.win01) + 32'(b4.win10)
                         + 32'(b4.win11)) / 4 + pcnt * 256);
        b5.pool_finish = b5.pool_start;
        b5.pool_pixel  = 16'((32'(b5.win00) + 32'(b5.win01) + 32'(b5.win10)
                         + 32'(b5.win11)) / 4);
    end

    always @(posedge clk) begin
        pcnt <= (b4.pool_start && !b4.pool_finish) ? pcnt + 1 : 0;
        cyc  <= cyc + 1;
    end

    logic        m_busy, m_done, m_rd_en, m_ps, m_wr_en;
    logic [15:0] m_rd_addr, m_wr_addr, m_wr_data;
    logic [63:0] m_win;

    always_comb begin
        m_busy    = sel ? b5.busy : b4.busy;
        m_done    = sel ? b5.done : b4.done;
        m_rd_en   = sel ? b5.rd_en : b4.rd_en;
        m_rd_addr = sel ? b5.rd_addr : b4.rd_addr;
        m_ps      = sel ? b5.pool_start : b4.pool_start;
        m_wr_en   = sel ? b5.wr_en : b4.wr_en;
        m_wr_addr = sel ? b5.wr_addr : b4.wr_addr;
        m_wr_data = sel ? b5.wr_data : b4.wr_data;
        m_win     = sel ? {b5.win00, b5.win01, b5.win10, b5.win11}
                        : {b4.win00, b4.win01, b4.win10, b4.win11};
    end

    int          ra[$];
    int          wa[$];
    int          wd[$];
    logic [63:0] winq[$];
    int          dq[$];
    int          ps_n = 0;

    always @(negedge clk) begin
        if (m_rd_en) ra.push_back(int'(m_rd_addr));
        if (m_wr_en) begin
            wa.push_back(int'(m_wr_addr));
            wd.push_back(int'(m_wr_data));
            winq.push_back(m_win);
        end
        if (m_done) dq.push_back(cyc);
        if (m_ps) ps_n <= ps_n + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_go(output int c);
        @(negedge clk);
        if (sel) b5.go = 1'b1;
        else b4.go = 1'b1;
        c = cyc;
        @(negedge clk);
        b4.go = 1'b0;
        b5.go = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (m_done) break;
            n++;
        end
        if (n >= 200) chk({name, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        bit big;
        int dly;
        int cycles;
        int starts;
        int wr[4];
        int win[4];
        int rd[16];
    } vec_t;

    initial begin
        vec_t v[3];
        int   bw, br, bp, bd, gc, gc2, n;

        v[0].big = 0; v[0].dly = 0; v[0].cycles = 29; v[0].starts = 4;
        v[0].wr  = '{14, 22, 46, 54};
        v[0].win = '{4, 8, 20, 24};
        v[0].rd  = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        v[1].big = 1; v[1].dly = 0; v[1].cycles = 29; v[1].starts = 4;
        v[1].wr  = '{16, 24, 56, 64};
        v[1].win = '{4, 8, 24, 28};
        v[1].rd  = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};
        v[2].big = 0; v[2].dly = 3; v[2].cycles = 41; v[2].starts = 16;
        v[2].wr  = '{782, 790, 814, 822};
        v[2].win = '{4, 8, 20, 24};
        v[2].rd  = v[0].rd;

        b4.go = 1'b0;
        b5.go = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", int'({b4.busy, b4.done, b4.rd_en, b4.pool_start, b4.wr_en}), 0);
        chk("rst_addr", int'(b4.rd_addr | b4.wr_addr), 0);
        chk("rst_data", int'(b4.wr_data | b4.win00 | b4.win01 | b4.win10 | b4.win11), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            sel = v[i].big;
            dly = v[i].dly;
            @(negedge clk);
            bw = wd.size(); br = ra.size(); bp = ps_n; bd = dq.size();
            pulse_go(gc);
            wait_done("scan");
            repeat (3) @(negedge clk);
            chk("writes", wd.size() - bw, 4);
            chk("reads", ra.size() - br, 16);
            chk("start_cycles", ps_n - bp, v[i].starts);
            chk("done_pulses", dq.size() - bd, 1);
            chk("busy_after", int'(m_busy), 0);
            if (dq.size() > bd) chk("go_to_done", dq[bd] - gc, v[i].cycles);
            for (int j = 0; j < 4; j++) begin
                if (wd.size() > bw + j) begin
                    chk("wr_addr", wa[bw+j], 1024 + j);
                    chk("wr_data", wd[bw+j], v[i].wr[j]);
                end
            end
            if (winq.size() > bw) begin
                chk("win00", int'(winq[bw][63:48]), v[i].win[0]);
                chk("win01", int'(winq[bw][47:32]), v[i].win[1]);
                chk("win10", int'(winq[bw][31:16]), v[i].win[2]);
                chk("win11", int'(winq[bw][15:0]), v[i].win[3]);
            end
            for (int j = 0; j < 16; j++) begin
                if (ra.size() > br + j) chk("rd_addr", ra[br+j], v[i].rd[j]);
            end
        end

        // go during F2 and during DONE is ignored
        sel = 1'b0;
        dly = 0;
        @(negedge clk);
        bw = wd.size(); br = ra.size(); bd = dq.size();
        pulse_go(gc);
        repeat (2) @(negedge clk);
        chk("in_f2_addr", int'(b4.rd_addr), 4);
        b4.go = 1'b1;
        @(negedge clk);
        b4.go = 1'b0;
        wait_done("ign");
        b4.go = 1'b1;
        @(negedge clk);
        b4.go = 1'b0;
        repeat (40) @(negedge clk);
        chk("ign_done_pulses", dq.size() - bd, 1);
        chk("ign_writes", wd.size() - bw, 4);
        chk("ign_reads", ra.size() - br, 16);
        chk("ign_busy", int'(m_busy), 0);
        if (dq.size() > bd) chk("ign_go_to_done", dq[bd] - gc, 29);

        // reset while window 2 is in POOL
        @(negedge clk);
        bw = wd.size(); bd = dq.size();
        pulse_go(gc);
        n = 0;
        while (!(m_ps && wd.size() - bw == 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_pool", int'(n < 100), 1);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", int'({b4.busy, b4.done, b4.rd_en, b4.pool_start, b4.wr_en}), 0);
        chk("abort_addr", int'(b4.rd_addr | b4.wr_addr), 0);
        chk("abort_data", int'(b4.wr_data | b4.win00 | b4.win01 | b4.win10 | b4.win11), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_writes", wd.size() - bw, 2);
        chk("abort_done", dq.size() - bd, 0);
        bw = wd.size(); br = ra.size();
        pulse_go(gc);
        wait_done("restart");
        repeat (2) @(negedge clk);
        if (ra.size() > br) chk("restart_rd0", ra[br], 0);
        chk("restart_writes", wd.size() - bw, 4);
        for (int j = 0; j < 4; j++) begin
            if (wd.size() > bw + j) chk("restart_data", wd[bw+j], v[0].wr[j]);
        end

        // second go in the cycle right after done
        @(negedge clk);
        bw = wd.size(); bd = dq.size();
        pulse_go(gc);
        wait_done("b2b_first");
        @(negedge clk);
        b4.go = 1'b1;
        gc2 = cyc;
        @(negedge clk);
        b4.go = 1'b0;
        wait_done("b2b_second");
        repeat (3) @(negedge clk);
        chk("b2b_done_pulses", dq.size() - bd, 2);
        chk("b2b_writes", wd.size() - bw, 8);
        if (dq.size() > bd + 1) chk("b2b_go_to_done", dq[bd+1] - gc2, 29);
        for (int j = 0; j < 4; j++) begin
            if (wd.size() > bw + 4 + j) begin
                chk("b2b_addr", wa[bw+4+j], 1024 + j);
                chk("b2b_data", wd[bw+4+j], v[0].wr[j]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
